// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback,
// with a single registered write stage and combinational forwarding to both read ports.
module regfile_wb_arbiter #(
  parameter int N  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_wa,
  input  logic [N-1:0]  alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_wa,
  input  logic [N-1:0]  mem_wd,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [N-1:0]  wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          fwd1_hit,
  output logic [N-1:0]  fwd1_data,
  output logic          fwd2_hit,
  output logic [N-1:0]  fwd2_data
);

  localparam logic [AW-1:0] XZR = '1;

  typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} pri_e;

  pri_e          state_q, state_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [N-1:0]  wd3_q, wd3_d;
  logic          grant_alu, grant_mem;
  logic [AW-1:0] sel_wa;
  logic [N-1:0]  sel_wd;

  // A lone requester always wins; the state only breaks ties.
  assign grant_alu = alu_valid & (~mem_valid | (state_q == PRI_ALU));
  assign grant_mem = mem_valid & (~alu_valid | (state_q == PRI_MEM));
  assign alu_ready = grant_alu & ~reset;
  assign mem_ready = grant_mem & ~reset;

  assign sel_wa = alu_ready ? alu_wa : mem_wa;
  assign sel_wd = alu_ready ? alu_wd : mem_wd;

  always_comb begin
    state_d = state_q;
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    if (alu_ready) begin
      state_d = PRI_MEM;
    end else if (mem_ready) begin
      state_d = PRI_ALU;
    end
    // A write to XZR is accepted and consumes its turn, but never enables the regfile.
    if (alu_ready | mem_ready) begin
      we3_d = (sel_wa != XZR);
      wa3_d = sel_wa;
      wd3_d = sel_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRI_ALU;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

  assign fwd1_hit  = we3_q & (ra1 == wa3_q) & (ra1 != XZR);
  assign fwd2_hit  = we3_q & (ra2 == wa3_q) & (ra2 != XZR);
  assign fwd1_data = fwd1_hit ? wd3_q : '0;
  assign fwd2_data = fwd2_hit ? wd3_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset, alternation and forwarding sequences.
module tb_regfile_wb_arbiter;

  localparam int N  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_wa = '0, mem_wa = '0, ra1 = '0, ra2 = '0;
  logic [N-1:0]  alu_wd = '0, mem_wd = '0;
  logic          we3, fwd1_hit, fwd2_hit;
  logic [AW-1:0] wa3;
  logic [N-1:0]  wd3, fwd1_data, fwd2_data;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
  );

  // Regfile model driven by the write port; X31 is deliberately not special-cased here.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  typedef struct {
    logic          av;
    logic [AW-1:0] awa;
    logic [N-1:0]  awd;
    logic          mv;
    logic [AW-1:0] mwa;
    logic [N-1:0]  mwd;
    logic [AW-1:0] r1, r2;
    logic          e_ardy, e_mrdy, e_we;
    logic [AW-1:0] e_wa;
    logic [N-1:0]  e_wd;
    logic          e_h1, e_h2;
    logic [N-1:0]  e_d1, e_d2;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic av, logic [AW-1:0] awa, logic [N-1:0] awd,
                              logic mv, logic [AW-1:0] mwa, logic [N-1:0] mwd,
                              logic [AW-1:0] r1, logic [AW-1:0] r2,
                              logic e_ardy, logic e_mrdy, logic e_we,
                              logic [AW-1:0] e_wa, logic [N-1:0] e_wd,
                              logic e_h1, logic [N-1:0] e_d1, logic e_h2, logic [N-1:0] e_d2);
    vec_t v;
    v.av = av; v.awa = awa; v.awd = awd; v.mv = mv; v.mwa = mwa; v.mwd = mwd;
    v.r1 = r1; v.r2 = r2; v.e_ardy = e_ardy; v.e_mrdy = e_mrdy; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_stage(input string tag, input logic e_we, input logic [AW-1:0] e_wa,
                             input logic [N-1:0] e_wd);
    chk({tag, "_we3"}, N'(we3), N'(e_we));
    chk({tag, "_wa3"}, N'(wa3), N'(e_wa));
    chk({tag, "_wd3"}, wd3, e_wd);
  endtask

  initial begin
    // Table, starting right after reset with priority on ALU.
    vecs[0] = mk(0, 0, 0,          0, 0, 0,      0, 0,   0, 0, 0, 0, 0,          0, 0, 0, 0);
    vecs[1] = mk(1, 5, 64'hA5,     0, 0, 0,      5, 0,   1, 0, 1, 5, 64'hA5,     1, 64'hA5, 0, 0);
    vecs[2] = mk(1, 1, 64'h11,     1, 2, 64'h22, 2, 1,   0, 1, 1, 2, 64'h22,     1, 64'h22, 0, 0);
    vecs[3] = mk(1, 1, 64'h11,     1, 2, 64'h22, 2, 1,   1, 0, 1, 1, 64'h11,     0, 0, 1, 64'h11);
    vecs[4] = mk(0, 0, 0,          1, 31, 64'h1, 31, 31, 0, 1, 0, 31, 64'h1,     0, 0, 0, 0);
    vecs[5] = mk(0, 0, 0,          0, 0, 0,      31, 31, 0, 0, 0, 31, 64'h1,     0, 0, 0, 0);
    vecs[6] = mk(1, 9, 64'h1234,   0, 0, 0,      9, 9,   1, 0, 1, 9, 64'h1234,   1, 64'h1234, 1, 64'h1234);
    vecs[7] = mk(0, 0, 0,          0, 0, 0,      9, 9,   0, 0, 0, 9, 64'h1234,   0, 0, 0, 0);
    vecs[8] = mk(1, 0, 64'h3,      0, 0, 0,      0, 4,   1, 0, 1, 0, 64'h3,      1, 64'h3, 0, 0);
    vecs[9] = mk(0, 0, 0,          1, 3, 64'h7,  3, 3,   0, 1, 1, 3, 64'h7,      1, 64'h7, 1, 64'h7);

    // Reset state.
    do_reset();
    #3;
    check_stage("rst", 1'b0, '0, '0);
    chk("rst_alu_ready", N'(alu_ready), '0);
    chk("rst_mem_ready", N'(mem_ready), '0);
    chk("rst_fwd1_hit", N'(fwd1_hit), '0);
    chk("rst_fwd2_hit", N'(fwd2_hit), '0);
    @(negedge clk);

    // Table: readies checked before the edge, stage and forwarding after it.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      alu_valid = vecs[i].av; alu_wa = vecs[i].awa; alu_wd = vecs[i].awd;
      mem_valid = vecs[i].mv; mem_wa = vecs[i].mwa; mem_wd = vecs[i].mwd;
      ra1 = vecs[i].r1; ra2 = vecs[i].r2;
      #2;
      chk($sformatf("v%0d_alu_ready", i), N'(alu_ready), N'(vecs[i].e_ardy));
      chk($sformatf("v%0d_mem_ready", i), N'(mem_ready), N'(vecs[i].e_mrdy));
      tick();
      check_stage($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd);
      chk($sformatf("v%0d_fwd1_hit", i), N'(fwd1_hit), N'(vecs[i].e_h1));
      chk($sformatf("v%0d_fwd1_data", i), fwd1_data, vecs[i].e_d1);
      chk($sformatf("v%0d_fwd2_hit", i), N'(fwd2_hit), N'(vecs[i].e_h2));
      chk($sformatf("v%0d_fwd2_data", i), fwd2_data, vecs[i].e_d2);
    end
    idle();
    tick();
    chk("rf_x5", rf[5], 64'hA5);
    chk("rf_x31", rf[31], '0);

    // Both requesters held from reset: grants alternate ALU, MEM, ALU, MEM.
    do_reset();
    alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 64'h11;
    mem_valid = 1'b1; mem_wa = 5'd2; mem_wd = 64'h22;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("rr%0d_alu_ready", k), N'(alu_ready), N'((k % 2) == 0));
      chk($sformatf("rr%0d_mem_ready", k), N'(mem_ready), N'((k % 2) == 1));
      tick();
      chk($sformatf("rr%0d_wa3", k), N'(wa3), ((k % 2) == 0) ? N'(1) : N'(2));
      chk($sformatf("rr%0d_wd3", k), wd3, ((k % 2) == 0) ? 64'h11 : 64'h22);
    end
    idle();

    // Both read ports hitting the same staged write, then one port moving away.
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 64'h1234;
    tick();
    idle();
    ra1 = 5'd9; ra2 = 5'd9;
    #1;
    chk("fw_h1", N'(fwd1_hit), 1);
    chk("fw_d1", fwd1_data, 64'h1234);
    chk("fw_h2", N'(fwd2_hit), 1);
    chk("fw_d2", fwd2_data, 64'h1234);
    ra2 = 5'd10;
    #1;
    chk("fw_h2_moved", N'(fwd2_hit), 0);
    chk("fw_d2_moved", fwd2_data, 0);
    chk("fw_h1_kept", N'(fwd1_hit), 1);
    tick();

    // Reset mid-operation: staged write dropped, readiness suppressed during reset.
    alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 64'h77;
    #2;
    chk("mr_alu_ready_pre", N'(alu_ready), 1);
    tick();
    check_stage("mr_staged", 1'b1, 5'd7, 64'h77);
    alu_wd = 64'h99;
    reset = 1'b1;
    #2;
    chk("mr_alu_ready_rst", N'(alu_ready), 0);
    tick();
    check_stage("mr_cleared", 1'b0, '0, '0);
    chk("mr_alu_ready_rst2", N'(alu_ready), 0);
    reset = 1'b0;
    #2;
    chk("mr_alu_ready_post", N'(alu_ready), 1);
    tick();
    check_stage("mr_represent", 1'b1, 5'd7, 64'h99);
    idle();
    tick();
    chk("mr_we3_idle", N'(we3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
